// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one registered divide-by-ten unit among N_REQ requesters;
// hundreds are stripped by repeated subtraction, grant-to-Done is 3+h cycles, Req is ignored while busy.
module bcd_conv_sched #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   Req,
  input  logic [8*N_REQ-1:0] Req_Data,
  output logic [N_REQ-1:0]   Ack,
  output logic               Busy,
  output logic               Done,
  output logic [IDW-1:0]     Done_Id,
  output logic [3:0]         Hun,
  output logic [3:0]         Ten,
  output logic [3:0]         One,
  output logic [7:0]         Div_Number,
  input  logic [3:0]         Div_Ten,
  input  logic [3:0]         Div_One
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUND    = 2'd1,
    ISSUE   = 2'd2,
    COLLECT = 2'd3
  } state_t;

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] LAST   = IDW'(N_REQ - 1);

  state_t         state;
  state_t         state_nxt;
  logic [7:0]     r_val;
  logic [1:0]     r_hun;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] ptr;

  logic [7:0]     opnd [N_REQ];
  logic           found;
  logic [IDW-1:0] win_id;
  logic [7:0]     win_dat;
  logic [N_REQ-1:0] ack_nxt;
  logic [IDW-1:0] ptr_nxt;

  logic grant;
  logic sub;
  logic load_div;
  logic collect;

  for (genvar g = 0; g < N_REQ; g++) begin : g_opnd
    assign opnd[g] = Req_Data[8*g +: 8];
  end

  // Scan from the pointer upward; offsets wrap modulo N_REQ so no index >= N_REQ is ever produced.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    found   = 1'b0;
    win_id  = '0;
    win_dat = '0;
    sum     = '0;
    idx     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      sum = {1'b0, ptr} + j[IDW:0];
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      idx = sum[IDW-1:0];
      if (!found && Req[idx]) begin
        found   = 1'b1;
        win_id  = idx;
        win_dat = opnd[idx];
      end
    end
  end

  always_comb begin
    ack_nxt         = '0;
    ack_nxt[win_id] = 1'b1;
    ptr_nxt         = (win_id == LAST) ? '0 : win_id + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    sub       = 1'b0;
    load_div  = 1'b0;
    collect   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant     = 1'b1;
          state_nxt = HUND;
        end
      end
      HUND: begin
        if (r_val >= 8'd100) begin
          sub = 1'b1;
        end else begin
          load_div  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = COLLECT;
      end
      COLLECT: begin
        collect   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_val      <= '0;
      r_hun      <= '0;
      r_id       <= '0;
      ptr        <= '0;
      Ack        <= '0;
      Done       <= 1'b0;
      Done_Id    <= '0;
      Hun        <= '0;
      Ten        <= '0;
      One        <= '0;
      Div_Number <= '0;
    end else begin
      Ack  <= '0;
      Done <= 1'b0;
      if (grant) begin
        r_val <= win_dat;
        r_hun <= '0;
        r_id  <= win_id;
        Ack   <= ack_nxt;
        ptr   <= ptr_nxt;
      end
      if (sub) begin
        r_val <= r_val - 8'd100;
        r_hun <= r_hun + 2'd1;
      end
      if (load_div) begin
        Div_Number <= r_val;
      end
      // Divide results are already registered in the shared unit; take them as they stand.
      if (collect) begin
        Hun     <= {2'b00, r_hun};
        Ten     <= Div_Ten;
        One     <= Div_One;
        Done_Id <= r_id;
        Done    <= 1'b1;
      end
    end
  end

  assign Busy = (state != IDLE) || Done;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: transaction-timing model plus directed literal checks and random traffic.
module tb_bcd_conv_sched;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [N-1:0]   Req = '0;
  logic [8*N-1:0] Req_Data = '0;
  logic [N-1:0]   Ack;
  logic           Busy;
  logic           Done;
  logic [IDW-1:0] Done_Id;
  logic [3:0]     Hun;
  logic [3:0]     Ten;
  logic [3:0]     One;
  logic [7:0]     Div_Number;
  logic [3:0]     Div_Ten = '0;
  logic [3:0]     Div_One = '0;

  bcd_conv_sched #(.N_REQ(N), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .Req_Data(Req_Data), .Ack(Ack), .Busy(Busy),
    .Done(Done), .Done_Id(Done_Id), .Hun(Hun), .Ten(Ten), .One(One),
    .Div_Number(Div_Number), .Div_Ten(Div_Ten), .Div_One(Div_One)
  );

  always #5 CLK = ~CLK;

  // Shared registered divide unit.
  always @(posedge CLK) begin
    Div_Ten <= 4'(Div_Number / 8'd10);
    Div_One <= 4'(Div_Number % 8'd10);
  end

  int total = 0;
  int bad   = 0;
  int e = 0;
  int m_ptr, m_free, busy_end, div_edge, div_val, pend_id, pend_val;
  int x_ack, x_done, x_busy, x_div, x_id, x_hun, x_ten, x_one;
  int bnd [8] = '{0, 99, 100, 199, 200, 255, 1, 155};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, e);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_free = 0; busy_end = -1; div_edge = -1; div_val = 0;
    pend_id = 0; pend_val = 0;
    x_ack = 0; x_done = 0; x_busy = 0; x_div = 0; x_id = 0; x_hun = 0; x_ten = 0; x_one = 0;
  endtask

  // Expected outputs after edge e, from the request levels seen at that edge.
  task automatic model_edge();
    int w;
    int v;
    w = -1;
    x_ack  = 0;
    x_done = 0;
    if (e >= m_free) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && Req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    if (w >= 0) begin
      v        = int'(Req_Data[8*w +: 8]);
      x_ack    = 1 << w;
      busy_end = e + 3 + v / 100;
      div_edge = e + 1 + v / 100;
      div_val  = v % 100;
      m_free   = e + 4 + v / 100;
      m_ptr    = (w + 1) % N;
      pend_id  = w;
      pend_val = v;
    end
    if (e == div_edge) x_div = div_val;
    if (e == busy_end) begin
      x_done = 1;
      x_id   = pend_id;
      x_hun  = pend_val / 100;
      x_ten  = (pend_val / 10) % 10;
      x_one  = pend_val % 10;
    end
    x_busy = (e <= busy_end) ? 1 : 0;
  endtask

  task automatic step();
    @(posedge CLK);
    e++;
    if (RST) model_edge();
    else model_reset();
    #1;
    chk("ack", int'(Ack), x_ack);
    chk("done", int'(Done), x_done);
    chk("busy", int'(Busy), x_busy);
    chk("div_number", int'(Div_Number), x_div);
    chk("done_id", int'(Done_Id), x_id);
    chk("hun", int'(Hun), x_hun);
    chk("ten", int'(Ten), x_ten);
    chk("one", int'(One), x_one);
  endtask

  task automatic wait_done(input int lat, input int id, input int eh, input int et, input int eo);
    int seen;
    seen = -1;
    for (int n = 1; n <= 8 && seen < 0; n++) begin
      step();
      if (Done) seen = n;
    end
    chk("lit_latency", seen, lat);
    chk("lit_done_id", int'(Done_Id), id);
    chk("lit_hun", int'(Hun), eh);
    chk("lit_ten", int'(Ten), et);
    chk("lit_one", int'(One), eo);
  endtask

  task automatic single(input int id, input int v, input int lat, input int eh, input int et,
                        input int eo, input int ediv);
    Req = '0;
    Req[id] = 1'b1;
    Req_Data[8*id +: 8] = 8'(v);
    step();
    chk("lit_ack", int'(Ack), 1 << id);
    Req[id] = 1'b0;
    wait_done(lat, id, eh, et, eo);
    chk("lit_div_number", int'(Div_Number), ediv);
    repeat (3) step();
  endtask

  function automatic logic [7:0] pick();
    if ($urandom_range(0, 9) < 3) return 8'(bnd[$urandom_range(0, 7)]);
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid [5];
    int ged [5];
    int ng;
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    int exp_gap [4] = '{4, 5, 4, 6};

    model_reset();
    step();
    step();
    chk("rst_ack", int'(Ack), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_div", int'(Div_Number), 0);
    RST = 1'b1;
    repeat (2) step();

    single(1, 47, 3, 0, 4, 7, 47);
    single(0, 255, 5, 2, 5, 5, 55);
    single(2, 100, 4, 1, 0, 0, 0);
    single(3, 0, 3, 0, 0, 0, 0);

    // All four held high: pointer is back at 0.
    Req = 4'b1111;
    Req_Data = {8'd255, 8'd42, 8'd150, 8'd5};
    ng = 0;
    for (int n = 0; n < 60 && ng < 5; n++) begin
      step();
      if (Ack != '0) begin
        for (int i = 0; i < N; i++) if (Ack[i]) gid[ng] = i;
        ged[ng] = e;
        ng++;
      end
    end
    chk("rr_grants", ng, 5);
    for (int i = 0; i < 5; i++) chk("rr_order", (i < ng) ? gid[i] : -1, exp_ord[i]);
    for (int i = 0; i < 4; i++) chk("rr_spacing", (i + 1 < ng) ? ged[i+1] - ged[i] : -1, exp_gap[i]);
    Req = '0;
    repeat (8) step();

    // Abort an operand 200 while it is still stripping hundreds.
    Req[0] = 1'b1;
    Req_Data[7:0] = 8'd200;
    step();
    Req = '0;
    step();
    RST = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", int'(Busy), 0);
    chk("abort_done", int'(Done), 0);
    chk("abort_hun", int'(Hun), 0);
    chk("abort_ten", int'(Ten), 0);
    chk("abort_one", int'(One), 0);
    chk("abort_div", int'(Div_Number), 0);
    Req[2] = 1'b1;
    Req_Data[23:16] = 8'd9;
    repeat (2) step();
    RST = 1'b1;
    step();
    chk("post_rst_ack", int'(Ack), 4);
    Req = '0;
    wait_done(3, 2, 0, 0, 9);
    repeat (3) step();

    // Random traffic; requesters react to the model's grants.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (Req[i]) begin
          if (x_ack[i]) begin
            if ($urandom_range(0, 1) == 1) Req_Data[8*i +: 8] = pick();
            else Req[i] = 1'b0;
          end else if ($urandom_range(0, 99) < 3) begin
            Req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 99) < 15) begin
          Req[i] = 1'b1;
          Req_Data[8*i +: 8] = pick();
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
